// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte/word helpers for the decrypt engine.
// The S-box tables are written out as full cases so they map directly to ROM/LUTs.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [2:0] {IDLE, KEY_EXP, INIT, ROUND, FINAL} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s;
    s = 8'h00;
    case (x)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] s;
    s = 8'h00;
    case (x)
      8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5; 8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
      8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e; 8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
      8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82; 8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
      8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44; 8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
      8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32; 8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
      8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b; 8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
      8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66; 8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
      8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49; 8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
      8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64; 8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
      8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc; 8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
      8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50; 8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
      8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57; 8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
      8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00; 8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
      8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05; 8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
      8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f; 8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
      8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03; 8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
      8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41; 8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
      8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce; 8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
      8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22; 8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
      8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8; 8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
      8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71; 8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
      8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e; 8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
      8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b; 8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
      8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe; 8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
      8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33; 8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
      8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59; 8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
      8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9; 8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
      8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f; 8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
      8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d; 8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
      8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c; 8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
      8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e; 8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
      8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63; 8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c; 8'hff: s = 8'h7d;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    r = 8'h00;
    case (i)
      4'd1: r = 8'h01; 4'd2: r = 8'h02; 4'd3: r = 8'h04; 4'd4: r = 8'h08; 4'd5: r = 8'h10;
      4'd6: r = 8'h20; 4'd7: r = 8'h40; 4'd8: r = 8'h80; 4'd9: r = 8'h1b; 4'd10: r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse-cipher round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns only when i_mix_en is set (the last round skips it).
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_rk,
  input  logic         i_mix_en,
  output logic [127:0] o_state
);

  logic [127:0] w_ark;
  logic [127:0] w_mix;

  // Byte k of the block sits at bits [127-8k -: 8]; row r of column c is byte 4c+r.
  always_comb begin
    w_ark = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        w_ark[127-8*(4*c+r) -: 8] = inv_sbox(i_state[127-8*(4*((c+4-r)%4)+r) -: 8])
                                   ^ i_rk[127-8*(4*c+r) -: 8];
  end

  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    w_mix = '0;
    a0 = 8'h00; a1 = 8'h00; a2 = 8'h00; a3 = 8'h00;
    for (int c = 0; c < 4; c++) begin
      a0 = w_ark[127-32*c -: 8];
      a1 = w_ark[119-32*c -: 8];
      a2 = w_ark[111-32*c -: 8];
      a3 = w_ark[103-32*c -: 8];
      w_mix[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      w_mix[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      w_mix[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      w_mix[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
  end

  assign o_state = i_mix_en ? w_mix : w_ark;

endmodule

// File: rtl/aes_decrypt_top.sv
// Iterative AES-128 decryptor, one round per clock. The key is expanded forward to
// rk10 and then walked backwards one round key per cycle, so no schedule is stored.
module aes_decrypt_top
  import aes_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  input  logic [0:127] Data_In,
  input  logic [0:127] Key,
  input  logic         Enable,
  output logic [0:127] Data_Out,
  output logic         Data_Out_VLD,
  output logic         Busy
);

  state_t       r_fsm;
  logic [3:0]   r_rnd;
  logic [127:0] r_ct;
  logic [127:0] r_key;
  logic [127:0] r_st;

  logic [31:0]  w_k0, w_k1, w_k2, w_k3;
  logic [31:0]  w_f0, w_f1, w_f2, w_f3;
  logic [31:0]  w_b0, w_b1, w_b2, w_b3;
  logic [7:0]   w_rc_fwd;
  logic [7:0]   w_rc_inv;
  logic         w_mix_en;
  logic [127:0] w_round;

  assign {w_k0, w_k1, w_k2, w_k3} = r_key;

  assign w_rc_fwd = rcon(r_rnd);
  assign w_f0 = w_k0 ^ sub_word(rot_word(w_k3)) ^ {w_rc_fwd, 24'h0};
  assign w_f1 = w_k1 ^ w_f0;
  assign w_f2 = w_k2 ^ w_f1;
  assign w_f3 = w_k3 ^ w_f2;

  // INIT steps rk10 -> rk9; the counter still reads past NR there, so pin rcon[10].
  assign w_rc_inv = (r_fsm == INIT) ? rcon(4'(NR)) : rcon(r_rnd);
  assign w_b3 = w_k3 ^ w_k2;
  assign w_b2 = w_k2 ^ w_k1;
  assign w_b1 = w_k1 ^ w_k0;
  assign w_b0 = w_k0 ^ sub_word(rot_word(w_b3)) ^ {w_rc_inv, 24'h0};

  assign w_mix_en = (r_fsm == ROUND);

  aes_inv_round u_round (
    .i_state  (r_st),
    .i_rk     (r_key),
    .i_mix_en (w_mix_en),
    .o_state  (w_round)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_fsm        <= IDLE;
      r_rnd        <= '0;
      r_ct         <= '0;
      r_key        <= '0;
      r_st         <= '0;
      Data_Out     <= '0;
      Data_Out_VLD <= 1'b0;
    end else begin
      Data_Out_VLD <= 1'b0;
      case (r_fsm)
        IDLE: begin
          if (Enable) begin
            r_ct  <= Data_In;
            r_key <= Key;
            r_rnd <= 4'd1;
            r_fsm <= KEY_EXP;
          end
        end
        KEY_EXP: begin
          r_key <= {w_f0, w_f1, w_f2, w_f3};
          r_rnd <= r_rnd + 4'd1;
          if (r_rnd == 4'(NR)) r_fsm <= INIT;
        end
        INIT: begin
          r_st  <= r_ct ^ r_key;
          r_key <= {w_b0, w_b1, w_b2, w_b3};
          r_rnd <= 4'(NR - 1);
          r_fsm <= ROUND;
        end
        ROUND: begin
          r_st  <= w_round;
          r_key <= {w_b0, w_b1, w_b2, w_b3};
          r_rnd <= r_rnd - 4'd1;
          if (r_rnd == 4'd1) r_fsm <= FINAL;
        end
        FINAL: begin
          Data_Out     <= w_round;
          Data_Out_VLD <= 1'b1;
          r_fsm        <= IDLE;
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign Busy = (r_fsm != IDLE);

endmodule

// File: tb/tb_aes_decrypt_top.sv
// Bench for aes_decrypt_top: known-answer vectors plus random loopback against a
// forward-cipher model whose S-box is derived from GF(2^8) inversion and the affine map.
module tb_aes_decrypt_top;

  logic         CLK;
  logic         RST;
  logic [0:127] Data_In;
  logic [0:127] Key;
  logic         Enable;
  logic [0:127] Data_Out;
  logic         Data_Out_VLD;
  logic         Busy;

  int vectors;
  int miscompares;
  int cyc;
  logic [7:0] sb [256];

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK10_2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] C3 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_decrypt_top dut (
    .CLK          (CLK),
    .RST          (RST),
    .Data_In      (Data_In),
    .Key          (Key),
    .Enable       (Enable),
    .Data_Out     (Data_Out),
    .Data_Out_VLD (Data_Out_VLD),
    .Busy         (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00; t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  // Forward AES-128 with a stored 44-word schedule; decryption is checked by loopback.
  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int k = 0; k < 16; k++) t[k] = sb[s[k]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*rnd + k/4][31-8*(k%4) -: 8];
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // Accept one block, then wait (bounded) for the VLD pulse.
  task automatic run_block(input logic [127:0] ct, input logic [127:0] key,
                           output int lat, output logic [127:0] dout);
    Data_In = ct; Key = key; Enable = 1'b1;
    tick();
    Enable = 1'b0;
    lat = 0;
    while (Data_Out_VLD !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    dout = Data_Out;
  endtask

  task automatic test_reset();
    RST = 1'b1; Enable = 1'b1; Data_In = C1; Key = K1;
    tick(); tick();
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    vectors++; if (Data_Out_VLD !== 1'b0) begin miscompares++; $display("FAIL reset_vld: got %b expected 0", Data_Out_VLD); end
    vectors++; if (Data_Out !== 128'h0) begin miscompares++; $display("FAIL reset_dout: got %h expected 0", Data_Out); end
    RST = 1'b0; Enable = 1'b0;
    tick();
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL reset_release_busy: got %b expected 0", Busy); end
  endtask

  task automatic test_known();
    logic [127:0] ct [3];
    logic [127:0] ky [3];
    logic [127:0] pt [3];
    logic [127:0] dout;
    int lat;
    ct[0] = C1; ky[0] = K1; pt[0] = P1;
    ct[1] = C2; ky[1] = K2; pt[1] = P2;
    ct[2] = C3; ky[2] = '0; pt[2] = '0;
    for (int i = 0; i < 3; i++) begin
      run_block(ct[i], ky[i], lat, dout);
      vectors++; if (lat != 21) begin miscompares++; $display("FAIL known%0d_latency: got %0d expected 21", i, lat); end
      vectors++; if (dout !== pt[i]) begin miscompares++; $display("FAIL known%0d_data: got %h expected %h", i, dout, pt[i]); end
      vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL known%0d_busy_at_vld: got %b expected 0", i, Busy); end
      tick();
      vectors++; if (Data_Out_VLD !== 1'b0) begin miscompares++; $display("FAIL known%0d_vld_pulse: got %b expected 0", i, Data_Out_VLD); end
    end
  endtask

  task automatic test_rk10();
    int n;
    Data_In = C2; Key = K2; Enable = 1'b1;
    tick();
    Enable = 1'b0;
    vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL rk10_busy_rise: got %b expected 1", Busy); end
    repeat (10) tick();
    vectors++; if (dut.r_key !== RK10_2) begin miscompares++; $display("FAIL rk10_value: got %h expected %h", dut.r_key, RK10_2); end
    n = 0;
    while (Data_Out_VLD !== 1'b1 && n < 40) begin tick(); n++; end
    vectors++; if (Data_Out !== P2 || n != 11) begin miscompares++; $display("FAIL rk10_result: got %h after %0d expected %h after 11", Data_Out, n, P2); end
  endtask

  task automatic test_back_to_back();
    int lat, t1, extra;
    Data_In = C1; Key = K1; Enable = 1'b1;
    tick();
    Data_In = C2; Key = K2;
    lat = 0;
    while (Data_Out_VLD !== 1'b1 && lat < 40) begin tick(); lat++; end
    vectors++; if (lat != 21 || Data_Out !== P1) begin miscompares++; $display("FAIL b2b_first: got %h lat %0d expected %h lat 21", Data_Out, lat, P1); end
    t1 = cyc;
    tick();
    Enable = 1'b0;
    vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL b2b_reaccept: got busy %b expected 1", Busy); end
    lat = 0;
    while (Data_Out_VLD !== 1'b1 && lat < 40) begin
      if (lat == 5) begin Enable = 1'b1; Data_In = rand128(); Key = rand128(); end
      else Enable = 1'b0;
      tick();
      lat++;
    end
    Enable = 1'b0;
    vectors++; if (cyc - t1 != 22) begin miscompares++; $display("FAIL b2b_spacing: got %0d expected 22", cyc - t1); end
    vectors++; if (Data_Out !== P2) begin miscompares++; $display("FAIL b2b_second: got %h expected %h", Data_Out, P2); end
    extra = 0;
    repeat (30) begin tick(); if (Data_Out_VLD === 1'b1) extra++; end
    vectors++; if (extra != 0) begin miscompares++; $display("FAIL b2b_dropped_enable: got %0d extra pulses expected 0", extra); end
  endtask

  task automatic test_reset_mid();
    int lat, extra;
    logic [127:0] dout;
    Data_In = C2; Key = K2; Enable = 1'b1;
    tick();
    Enable = 1'b0;
    repeat (15) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    vectors++; if (Busy !== 1'b0 || Data_Out !== 128'h0) begin miscompares++; $display("FAIL midrst_state: got busy %b dout %h expected 0/0", Busy, Data_Out); end
    extra = 0;
    repeat (30) begin tick(); if (Data_Out_VLD === 1'b1) extra++; end
    vectors++; if (extra != 0) begin miscompares++; $display("FAIL midrst_no_vld: got %0d pulses expected 0", extra); end
    run_block(C1, K1, lat, dout);
    vectors++; if (lat != 21 || dout !== P1) begin miscompares++; $display("FAIL midrst_restart: got %h lat %0d expected %h lat 21", dout, lat, P1); end
  endtask

  task automatic test_scrambled_inputs();
    logic [127:0] k, p, c;
    int lat;
    for (int i = 0; i < 8; i++) begin
      k = rand128(); p = rand128(); c = aes_enc(p, k);
      Data_In = c; Key = k; Enable = 1'b1;
      tick();
      Enable = 1'b0;
      lat = 0;
      while (Data_Out_VLD !== 1'b1 && lat < 40) begin
        Data_In = rand128(); Key = rand128();
        tick();
        lat++;
      end
      vectors++; if (lat != 21 || Data_Out !== p) begin miscompares++; $display("FAIL scramble%0d: got %h lat %0d expected %h lat 21", i, Data_Out, lat, p); end
    end
  endtask

  task automatic test_loopback();
    logic [127:0] k, p, dout;
    int lat;
    for (int i = 0; i < 16; i++) begin
      k = rand128(); p = rand128();
      if (i == 0) k = '1;
      if (i == 1) p = '1;
      run_block(aes_enc(p, k), k, lat, dout);
      vectors++; if (lat != 21 || dout !== p) begin miscompares++; $display("FAIL loopback%0d: got %h lat %0d expected %h lat 21", i, dout, lat, p); end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    RST = 1'b1; Enable = 1'b0; Data_In = '0; Key = '0;
    build_sbox();
    test_reset();
    test_known();
    test_rk10();
    test_back_to_back();
    test_reset_mid();
    test_scrambled_inputs();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
